alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one little_alu instance.
- Captures a requester's operands and opcode, then holds start_op to the ALU until end_op arrives (multi-cycle ops included) and returns the result to the winning requester.
- Provides a timeout guard and a completed-operation counter.
- Sits between the two datapath clients and the ALU; the ALU itself is not instantiated inside.

Parameters:
- TIMEOUT_CYCLES, 8: maximum cycles spent in BUSY before an error response is forced; legal range 2..255.
- CNT_W, 16: width of the ops_done counter.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset_p  input  1  asynchronous, active-high reset; no synchronous reset path.
- req  input  2  per-requester level request; bit i = requester i.
- a_in0, a_in1  input  16 each  operand A for requester 0 / 1.
- b_in0, b_in1  input  16 each  operand B for requester 0 / 1.
- op_in0, op_in1  input  3 each  opcode for requester 0 / 1.
- gnt  output  2  one-hot, one-cycle pulse; operands of that requester were captured.
- rsp_valid  output  2  one-hot, one-cycle pulse; rsp_result/rsp_err valid for that requester.
- rsp_result  output  32  result of the completed operation.
- rsp_err  output  1  qualified by rsp_valid; 1 = timeout, rsp_result forced to 0.
- busy  output  1  high in any state other than IDLE.
- ops_done  output  CNT_W  count of responses issued (including error responses); wraps to 0.
- alu_start_op  output  1  to ALU start_op.
- alu_a, alu_b  output  16 each  to ALU A/B; driven from captured registers.
- alu_op_sel  output  4  to ALU op_sel; {1'b0, captured opcode}.
- alu_end_op  input  1  from ALU end_op.
- alu_result  input  32  from ALU result; sampled only when alu_end_op=1 in BUSY.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; gnt=0, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0, ops_done=0.
  - alu_start_op=0, alu_a=0, alu_b=0, alu_op_sel=0; priority pointer -> requester 0.
  - Reset mid-operation abandons the transaction: no rsp_valid is issued and the ALU sees start_op drop in the same cycle.
- FSM states: IDLE, BUSY, RESP. All outputs are registered, or decoded from state and captured registers only.
- IDLE:
  - If req!=0 at a posedge, select the winner (round-robin), capture its a/b/op, and go to BUSY.
  - gnt[winner]=1 for the first BUSY cycle only.
  - With req=0, stay in IDLE.
- Round-robin:
  - If only one req bit is set, it wins.
  - If both are set, the requester with priority wins; priority then passes to the other requester.
  - A single-requester win also moves priority to the other requester.
- BUSY:
  - alu_start_op=1 continuously; alu_a/alu_b/alu_op_sel stay stable for the whole state.
  - A busy counter starts at 1 on entry and increments each cycle.
  - If alu_end_op=1 at a posedge: capture alu_result into rsp_result, rsp_err=0, go to RESP.
  - Otherwise, if the counter equals TIMEOUT_CYCLES: rsp_result=0, rsp_err=1, go to RESP.
  - If end_op and timeout occur at the same edge, end_op wins and no error is reported.
- RESP (exactly one cycle):
  - alu_start_op=0, rsp_valid[owner]=1, ops_done increments by 1 (modulo 2^CNT_W).
  - Next state is always IDLE. This gives the ALU one cycle with start_op low before the next op.
- Latency:
  - ALU asserts end_op in BUSY cycle k (k=1 is the first BUSY cycle) -> rsp_valid in cycle k+1.
  - Minimum req-sample-to-rsp_valid is 2 cycles; minimum issue-to-issue is 3 cycles.
- Request handling:
  - Requests arriving during BUSY or RESP are not granted; a held req is considered on the next IDLE edge.
  - Requesters keep req and operands stable until gnt. Operands may change after gnt without affecting the transaction.
  - A req still high after rsp_valid starts a new transaction.
- Spurious inputs: alu_end_op in IDLE or RESP is ignored; no state change and no counter change.
- Opcode: passed through unmodified, including 000 (no_op) and 110/111; no opcode is rejected by the arbiter.

Test Plan:
1. Reset then single req[0], op=001, A=16'h0003, B=16'h0004; ALU model end_op in BUSY cycle 1 with result 7 -> gnt=01 next cycle; rsp_valid=01, rsp_result=32'h7, rsp_err=0, ops_done=1.
2. Both req=11 held, op0=011, op1=101 -> grant order 0,1,0,1; gnt never asserted during BUSY/RESP; issue-to-issue spacing is 3 cycles.
3. MUL: op=100, A=16'hFFFF, B=16'h0002; end_op in BUSY cycle 3 with result 32'h1FFFE -> alu_start_op high exactly 3 cycles; rsp_result=32'h0001FFFE on rsp_valid in cycle 4.
4. Timeout: ALU model never asserts end_op, TIMEOUT_CYCLES=8 -> RESP after the 8th BUSY cycle; rsp_err=1, rsp_result=0; ops_done increments.
5. Boundary: end_op asserted exactly in BUSY cycle 8 -> rsp_err=0 with the ALU result. Separately, end_op pulsed while in IDLE -> no state change.
6. Reset_p asserted asynchronously mid-BUSY of a MUL -> alu_start_op, busy, gnt, rsp_valid all 0 before the next posedge; ops_done=0; after release, req=11 grants requester 0 first.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin arbiter/sequencer in front of a
//               shared little_alu, with busy timeout and completed-op counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int TIMEOUT_CYCLES = 8,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [1:0]       req,
    input  logic [15:0]      a_in0,
    input  logic [15:0]      a_in1,
    input  logic [15:0]      b_in0,
    input  logic [15:0]      b_in1,
    input  logic [2:0]       op_in0,
    input  logic [2:0]       op_in1,
    output logic [1:0]       gnt,
    output logic [1:0]       rsp_valid,
    output logic [31:0]      rsp_result,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done,
    output logic             alu_start_op,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [3:0]       alu_op_sel,
    input  logic             alu_end_op,
    input  logic [31:0]      alu_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0]       c_timeout = 8'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    state_t           r_state_q,      w_state_d;
    logic             r_prio_q,       w_prio_d;
    logic             r_owner_q,      w_owner_d;
    logic [15:0]      r_a_q,          w_a_d;
    logic [15:0]      r_b_q,          w_b_d;
    logic [2:0]       r_op_q,         w_op_d;
    logic [1:0]       r_gnt_q,        w_gnt_d;
    logic [1:0]       r_rsp_valid_q,  w_rsp_valid_d;
    logic [31:0]      r_rsp_result_q, w_rsp_result_d;
    logic             r_rsp_err_q,    w_rsp_err_d;
    logic [CNT_W-1:0] r_ops_done_q,   w_ops_done_d;
    logic [7:0]       r_bcnt_q,       w_bcnt_d;

    // r_prio_q = 1 means requester 1 currently holds priority
    logic w_win;
    assign w_win = (req == 2'b10) || ((req == 2'b11) && r_prio_q);

    always_comb begin
        w_state_d      = r_state_q;
        w_prio_d       = r_prio_q;
        w_owner_d      = r_owner_q;
        w_a_d          = r_a_q;
        w_b_d          = r_b_q;
        w_op_d         = r_op_q;
        w_gnt_d        = 2'b00;
        w_rsp_valid_d  = 2'b00;
        w_rsp_result_d = r_rsp_result_q;
        w_rsp_err_d    = r_rsp_err_q;
        w_ops_done_d   = r_ops_done_q;
        w_bcnt_d       = r_bcnt_q;

        case (r_state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    w_state_d = S_BUSY;
                    w_owner_d = w_win;
                    w_prio_d  = ~w_win;
                    w_a_d     = w_win ? a_in1  : a_in0;
                    w_b_d     = w_win ? b_in1  : b_in0;
                    w_op_d    = w_win ? op_in1 : op_in0;
                    w_gnt_d   = w_win ? 2'b10  : 2'b01;
                    w_bcnt_d  = 8'd1;
                end
            end
            S_BUSY: begin
                w_bcnt_d = r_bcnt_q + 8'd1;
                // end_op has precedence over a timeout on the same edge
                if (alu_end_op) begin
                    w_state_d      = S_RESP;
                    w_rsp_result_d = alu_result;
                    w_rsp_err_d    = 1'b0;
                    w_rsp_valid_d  = r_owner_q ? 2'b10 : 2'b01;
                    w_ops_done_d   = r_ops_done_q + c_one;
                end else if (r_bcnt_q == c_timeout) begin
                    w_state_d      = S_RESP;
                    w_rsp_result_d = 32'd0;
                    w_rsp_err_d    = 1'b1;
                    w_rsp_valid_d  = r_owner_q ? 2'b10 : 2'b01;
                    w_ops_done_d   = r_ops_done_q + c_one;
                end
            end
            S_RESP: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state_q      <= S_IDLE;
            r_prio_q       <= 1'b0;
            r_owner_q      <= 1'b0;
            r_a_q          <= 16'd0;
            r_b_q          <= 16'd0;
            r_op_q         <= 3'd0;
            r_gnt_q        <= 2'b00;
            r_rsp_valid_q  <= 2'b00;
            r_rsp_result_q <= 32'd0;
            r_rsp_err_q    <= 1'b0;
            r_ops_done_q   <= '0;
            r_bcnt_q       <= 8'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_prio_q       <= w_prio_d;
            r_owner_q      <= w_owner_d;
            r_a_q          <= w_a_d;
            r_b_q          <= w_b_d;
            r_op_q         <= w_op_d;
            r_gnt_q        <= w_gnt_d;
            r_rsp_valid_q  <= w_rsp_valid_d;
            r_rsp_result_q <= w_rsp_result_d;
            r_rsp_err_q    <= w_rsp_err_d;
            r_ops_done_q   <= w_ops_done_d;
            r_bcnt_q       <= w_bcnt_d;
        end
    end

    // start_op is decoded from state so an async reset drops it immediately
    assign busy         = (r_state_q != S_IDLE);
    assign alu_start_op = (r_state_q == S_BUSY);
    assign alu_a        = r_a_q;
    assign alu_b        = r_b_q;
    assign alu_op_sel   = {1'b0, r_op_q};
    assign gnt          = r_gnt_q;
    assign rsp_valid    = r_rsp_valid_q;
    assign rsp_result   = r_rsp_result_q;
    assign rsp_err      = r_rsp_err_q;
    assign ops_done     = r_ops_done_q;

endmodule
`default_nettype wire
